pio_rx_req_decoder: RTL

- Request side of the PIO target path: consumes host TLPs from the PCIe core's 64-bit AXI4-Stream RX interface.
- Decodes single-DW memory reads and writes, drives the register-file read/write port (rd_addr/rd_be, wr_addr/wr_be/wr_data/wr_en, wr_busy).
- Requests a completion from the TX engine for each read and stalls further reception until the TX engine reports it sent.

---
 rtl/pio_rx_req_decoder_pkg.sv | 44 ++++
 rtl/pio_rx_bar_decode.sv | 24 ++
 rtl/pio_rx_req_decoder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_rx_req_decoder_pkg.sv
// Shared definitions for the PIO RX request decoder: TLP {fmt,type} codes,
// register-file region codes, FSM states and the lower-address helper.
package pio_rx_req_decoder_pkg;

    localparam logic [6:0] MRD32 = 7'b0000000;
    localparam logic [6:0] MRD64 = 7'b0100000;
    localparam logic [6:0] MWR32 = 7'b1000000;
    localparam logic [6:0] MWR64 = 7'b1100000;

    typedef enum logic [1:0] {
        REG_NONE = 2'b00,
        REG_BAR0 = 2'b01,
        REG_BAR2 = 2'b10,
        REG_ROM  = 2'b11
    } region_e;

    typedef enum logic [3:0] {
        IDLE,
        RD32_ADDR,
        WR32_ADDR,
        RD64_ADDR,
        WR64_ADDR,
        WR64_DATA,
        WR_WAIT,
        RD_LAT,
        WAIT_COMPL,
        DRAIN
    } state_e;

    // Byte offset of the first enabled byte; an all-zero first_be maps to 0.
    function automatic logic [1:0] lower_addr(input logic [3:0] first_be);
        logic [1:0] la;
        casez (first_be)
            4'b0000: la = 2'b00;
            4'b???1: la = 2'b00;
            4'b??10: la = 2'b01;
            4'b?100: la = 2'b10;
            4'b1000: la = 2'b11;
            default: la = 2'b00;
        endcase
        return la;
    endfunction

endpackage

// File: rtl/pio_rx_bar_decode.sv
// Maps the PCIe core's bar_hit vector onto a register-file region code.
// Only BAR0, BAR2 and the expansion ROM are backed; the lowest hit wins.
module pio_rx_bar_decode
    import pio_rx_req_decoder_pkg::*;
(
    input  logic [6:0] bar_hit_i,
    output region_e    region_o
);

    logic unused_bar_bits;
    assign unused_bar_bits = ^{bar_hit_i[5:3], bar_hit_i[1]};

    always_comb begin
        region_o = REG_NONE;
        if (bar_hit_i[0]) begin
            region_o = REG_BAR0;
        end else if (bar_hit_i[2]) begin
            region_o = REG_BAR2;
        end else if (bar_hit_i[6]) begin
            region_o = REG_ROM;
        end
    end

endmodule

// File: rtl/pio_rx_req_decoder.sv
// PIO target request decoder: parses MRd/MWr TLPs from the 64-bit AXI4-Stream
// RX port, drives the register-file port and requests completions for reads.
module pio_rx_req_decoder
    import pio_rx_req_decoder_pkg::*;
#(
    parameter int TCQ = 1
) (
    input  logic        clk,
    input  logic        sys_rst,

    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,

    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        wr_en,
    input  logic        wr_busy,

    output logic        req_compl,
    output logic        req_compl_wd,
    input  logic        compl_done,

    output logic [2:0]  req_tc,
    output logic        req_td,
    output logic        req_ep,
    output logic [1:0]  req_attr,
    output logic [9:0]  req_len,
    output logic [15:0] req_rid,
    output logic [7:0]  req_tag,
    output logic [7:0]  req_be,
    output logic [12:0] req_addr
);

    // Registers are zero-delay; TCQ only survives for drop-in compatibility.
    logic unused_ok;
    assign unused_ok = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:9],
                         m_axis_rx_tuser[1:0], (TCQ != 0)};

    state_e      state_q, state_d;
    region_e     region_q, region_d;
    logic [11:0] addr_dw_q, addr_dw_d;

    logic [13:0] rd_addr_q, rd_addr_d;
    logic [3:0]  rd_be_q, rd_be_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_be_q, wr_be_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;

    logic        req_compl_q, req_compl_d;
    logic        req_compl_wd_q, req_compl_wd_d;
    logic [2:0]  req_tc_q, req_tc_d;
    logic        req_td_q, req_td_d;
    logic        req_ep_q, req_ep_d;
    logic [1:0]  req_attr_q, req_attr_d;
    logic [9:0]  req_len_q, req_len_d;
    logic [15:0] req_rid_q, req_rid_d;
    logic [7:0]  req_tag_q, req_tag_d;
    logic [7:0]  req_be_q, req_be_d;
    logic [12:0] req_addr_q, req_addr_d;

    region_e     bar_region;
    logic [6:0]  hdr_kind;
    logic        is_mem_req;
    logic        write_ok;
    logic        rx_ready;
    logic        rd_beat;
    logic [11:0] rd_dw;
    logic        data_beat;
    logic [11:0] wr_dw;
    logic [31:0] wr_payload;

    pio_rx_bar_decode u_bar_decode (
        .bar_hit_i (m_axis_rx_tuser[8:2]),
        .region_o  (bar_region)
    );

    assign hdr_kind   = m_axis_rx_tdata[30:24];
    assign is_mem_req = hdr_kind inside {MRD32, MRD64, MWR32, MWR64};
    assign write_ok   = (req_len_q == 10'd1) && !req_ep_q;

    always_comb begin
        state_d        = state_q;
        region_d       = region_q;
        addr_dw_d      = addr_dw_q;
        rd_addr_d      = rd_addr_q;
        rd_be_d        = rd_be_q;
        wr_addr_d      = wr_addr_q;
        wr_be_d        = wr_be_q;
        wr_data_d      = wr_data_q;
        wr_en_d        = 1'b0;
        req_compl_d    = req_compl_q;
        req_compl_wd_d = req_compl_wd_q;
        req_tc_d       = req_tc_q;
        req_td_d       = req_td_q;
        req_ep_d       = req_ep_q;
        req_attr_d     = req_attr_q;
        req_len_d      = req_len_q;
        req_rid_d      = req_rid_q;
        req_tag_d      = req_tag_q;
        req_be_d       = req_be_q;
        req_addr_d     = req_addr_q;
        rx_ready       = 1'b0;
        rd_beat        = 1'b0;
        rd_dw          = '0;
        data_beat      = 1'b0;
        wr_dw          = '0;
        wr_payload     = '0;

        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (m_axis_rx_tvalid) begin
                    if (is_mem_req) begin
                        req_tc_d   = m_axis_rx_tdata[22:20];
                        req_td_d   = m_axis_rx_tdata[15];
                        req_ep_d   = m_axis_rx_tdata[14];
                        req_attr_d = m_axis_rx_tdata[13:12];
                        req_len_d  = m_axis_rx_tdata[9:0];
                        req_rid_d  = m_axis_rx_tdata[63:48];
                        req_tag_d  = m_axis_rx_tdata[47:40];
                        req_be_d   = m_axis_rx_tdata[39:32];
                        region_d   = bar_region;
                    end
                    case (hdr_kind)
                        MRD32:   state_d = RD32_ADDR;
                        MRD64:   state_d = RD64_ADDR;
                        MWR32:   state_d = WR32_ADDR;
                        MWR64:   state_d = WR64_ADDR;
                        default: if (!m_axis_rx_tlast) state_d = DRAIN;
                    endcase
                end
            end
            RD32_ADDR: begin
                rx_ready = 1'b1;
                rd_beat  = m_axis_rx_tvalid;
                rd_dw    = m_axis_rx_tdata[13:2];
            end
            RD64_ADDR: begin
                rx_ready = 1'b1;
                rd_beat  = m_axis_rx_tvalid;
                rd_dw    = m_axis_rx_tdata[45:34];
            end
            WR32_ADDR: begin
                rx_ready   = 1'b1;
                data_beat  = m_axis_rx_tvalid;
                wr_dw      = m_axis_rx_tdata[13:2];
                wr_payload = m_axis_rx_tdata[63:32];
            end
            WR64_ADDR: begin
                rx_ready = 1'b1;
                if (m_axis_rx_tvalid) begin
                    addr_dw_d = m_axis_rx_tdata[45:34];
                    state_d   = WR64_DATA;
                end
            end
            WR64_DATA: begin
                rx_ready   = 1'b1;
                data_beat  = m_axis_rx_tvalid;
                wr_dw      = addr_dw_q;
                wr_payload = m_axis_rx_tdata[31:0];
            end
            WR_WAIT: begin
                if (!wr_busy) begin
                    wr_en_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_LAT: begin
                req_compl_d = 1'b1;
                state_d     = WAIT_COMPL;
            end
            WAIT_COMPL: begin
                if (compl_done) begin
                    req_compl_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                rx_ready = 1'b1;
                if (m_axis_rx_tvalid && m_axis_rx_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rd_beat) begin
            rd_addr_d      = {region_q, rd_dw};
            rd_be_d        = req_be_q[3:0];
            req_addr_d     = {rd_dw[10:0], lower_addr(req_be_q[3:0])};
            req_compl_wd_d = 1'b1;
            state_d        = RD_LAT;
        end

        // Address/data are registered even when busy so they hold through WR_WAIT.
        if (data_beat) begin
            if (write_ok) begin
                wr_addr_d = {region_q, wr_dw};
                wr_be_d   = req_be_q;
                wr_data_d = wr_payload;
                if (wr_busy) begin
                    state_d = WR_WAIT;
                end else begin
                    wr_en_d = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                state_d = m_axis_rx_tlast ? IDLE : DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            region_q       <= REG_NONE;
            addr_dw_q      <= '0;
            rd_addr_q      <= '0;
            rd_be_q        <= '0;
            wr_addr_q      <= '0;
            wr_be_q        <= '0;
            wr_data_q      <= '0;
            wr_en_q        <= 1'b0;
            req_compl_q    <= 1'b0;
            req_compl_wd_q <= 1'b0;
            req_tc_q       <= '0;
            req_td_q       <= 1'b0;
            req_ep_q       <= 1'b0;
            req_attr_q     <= '0;
            req_len_q      <= '0;
            req_rid_q      <= '0;
            req_tag_q      <= '0;
            req_be_q       <= '0;
            req_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            region_q       <= region_d;
            addr_dw_q      <= addr_dw_d;
            rd_addr_q      <= rd_addr_d;
            rd_be_q        <= rd_be_d;
            wr_addr_q      <= wr_addr_d;
            wr_be_q        <= wr_be_d;
            wr_data_q      <= wr_data_d;
            wr_en_q        <= wr_en_d;
            req_compl_q    <= req_compl_d;
            req_compl_wd_q <= req_compl_wd_d;
            req_tc_q       <= req_tc_d;
            req_td_q       <= req_td_d;
            req_ep_q       <= req_ep_d;
            req_attr_q     <= req_attr_d;
            req_len_q      <= req_len_d;
            req_rid_q      <= req_rid_d;
            req_tag_q      <= req_tag_d;
            req_be_q       <= req_be_d;
            req_addr_q     <= req_addr_d;
        end
    end

    assign m_axis_rx_tready = rx_ready;
    assign rd_addr          = rd_addr_q;
    assign rd_be            = rd_be_q;
    assign wr_addr          = wr_addr_q;
    assign wr_be            = wr_be_q;
    assign wr_data          = wr_data_q;
    assign wr_en            = wr_en_q;
    assign req_compl        = req_compl_q;
    assign req_compl_wd     = req_compl_wd_q;
    assign req_tc           = req_tc_q;
    assign req_td           = req_td_q;
    assign req_ep           = req_ep_q;
    assign req_attr         = req_attr_q;
    assign req_len          = req_len_q;
    assign req_rid          = req_rid_q;
    assign req_tag          = req_tag_q;
    assign req_be           = req_be_q;
    assign req_addr         = req_addr_q;

endmodule
